// File: rtl/cic_interp_upsamp_ce.sv
// Multi-channel CIC interpolator (N combs at the input rate, N integrators at the output rate)
// with clock-enable rate generation and an in_req sample handshake.
module cic_interp_upsamp_ce #(
   parameter int NCH      = 2,
   parameter int IN_W     = 32,
   parameter int N        = 2,
   parameter int LOG2R    = 3,
   parameter int BASE_DIV = 18,
   parameter int OUT_W    = IN_W + (N - 1) * LOG2R
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 en,
   input  logic [1:0]           rate_sel,
   input  logic [NCH*IN_W-1:0]  in_data,
   output logic                 in_req,
   output logic [NCH*OUT_W-1:0] out_data,
   output logic                 out_valid
);
   localparam int            BW       = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;
   localparam logic [BW-1:0] BCNT_MAX = BW'(BASE_DIV - 1);

   logic [BW-1:0]    bcnt;
   logic [2:0]       dcnt;
   logic [2:0]       dmask;
   logic [LOG2R-1:0] ph;
   logic [1:0]       rate_act;
   logic             base_tick;
   logic             out_tick;
   logic             in_tick;

   logic signed [OUT_W-1:0] dly       [NCH][N];
   logic signed [OUT_W-1:0] dly_nxt   [NCH][N];
   logic signed [OUT_W-1:0] comb_reg  [NCH];
   logic signed [OUT_W-1:0] comb_nxt  [NCH];
   logic signed [OUT_W-1:0] integ     [NCH][N];
   logic signed [OUT_W-1:0] integ_nxt [NCH][N];
   logic signed [OUT_W-1:0] acc;
   logic signed [OUT_W-1:0] x;

   // NOTE: every signal driven here gets a value on every path, otherwise a latch is inferred.
   always_comb begin
      dmask     = 3'(7 >> rate_act);
      base_tick = en && (bcnt == BCNT_MAX);
      out_tick  = base_tick && ((dcnt & dmask) == dmask);
      in_tick   = out_tick && (ph == '0);
   end

   assign in_req = in_tick;

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         bcnt     <= '0;
         dcnt     <= '0;
         ph       <= '0;
         rate_act <= rate_sel;
      end else if (en) begin
         bcnt <= base_tick ? '0 : bcnt + 1'b1;
         // Restarting dcnt at each input boundary makes the first spacing after a rate change exact.
         if (in_tick)
            dcnt <= '0;
         else if (base_tick)
            dcnt <= dcnt + 1'b1;
         if (out_tick)
            ph <= ph + 1'b1;
         if (in_tick)
            rate_act <= rate_sel;
      end
   end

   // Comb chain at the input rate, zero-stuffed feed and integrator chain at the output rate.
   always_comb begin
      acc = '0;
      x   = '0;
      for (int c = 0; c < NCH; c++) begin
         acc = OUT_W'($signed(in_data[c*IN_W +: IN_W]));
         for (int k = 0; k < N; k++) begin
            dly_nxt[c][k] = acc;
            acc           = acc - dly[c][k];
         end
         comb_nxt[c] = acc;
         x = (ph == '0) ? comb_reg[c] : '0;
         integ_nxt[c][0] = integ[c][0] + x;
         for (int k = 1; k < N; k++)
            integ_nxt[c][k] = integ[c][k] + integ[c][k-1];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         // NOTE: the register arrays hold filter history, so each element is cleared explicitly.
         for (int c = 0; c < NCH; c++) begin
            comb_reg[c] <= '0;
            for (int k = 0; k < N; k++) begin
               dly[c][k]   <= '0;
               integ[c][k] <= '0;
            end
         end
      end else begin
         out_valid <= out_tick;
         if (in_tick) begin
            dly      <= dly_nxt;
            comb_reg <= comb_nxt;
         end
         if (out_tick) begin
            integ <= integ_nxt;
            for (int c = 0; c < NCH; c++)
               out_data[c*OUT_W +: OUT_W] <= integ_nxt[c][N-1];
         end
      end
   end

endmodule

// File: tb/tb_cic_interp_upsamp_ce.sv
// Bench for cic_interp_upsamp_ce: tick-schedule model plus an FIR-form CIC reference
// (impulse response = boxcar(R) convolved N times) applied to the captured samples.
module tb_cic_interp_upsamp_ce;
   localparam int NCH      = 2;
   localparam int IN_W     = 32;
   localparam int N        = 2;
   localparam int LOG2R    = 3;
   localparam int R        = 1 << LOG2R;
   localparam int BASE_DIV = 18;
   localparam int OUT_W    = IN_W + (N - 1) * LOG2R;
   localparam int D        = R + N - 1;
   localparam int HL       = N * (R - 1) + 1;
   localparam int MAXS     = 1024;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 en;
   logic [1:0]           rate_sel;
   logic [NCH*IN_W-1:0]  in_data;
   logic                 in_req;
   logic [NCH*OUT_W-1:0] out_data;
   logic                 out_valid;

   cic_interp_upsamp_ce #(
      .NCH(NCH), .IN_W(IN_W), .N(N), .LOG2R(LOG2R), .BASE_DIV(BASE_DIV)
   ) dut (
      .clk(clk), .reset(reset), .en(en), .rate_sel(rate_sel), .in_data(in_data),
      .in_req(in_req), .out_data(out_data), .out_valid(out_valid)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model state
   longint           h    [HL];
   longint           htmp [HL];
   longint           samp [NCH][MAXS];
   int               n_samp, kcnt, next_tick, tick_m, rate_act, cyc;
   logic             exp_valid, exp_req;
   logic [OUT_W-1:0] exp_data [NCH];
   int               last_valid_cyc, valid_gap, last_req_cyc, req_gap;
   longint           gain;

   function automatic int period(input int r);
      return BASE_DIV << (3 - r);
   endfunction

   function automatic logic [OUT_W-1:0] cic_out(input int ch, input int m);
      longint acc;
      acc = 0;
      for (int j = 0; j < HL; j++) begin
         int n;
         n = m - D - j;
         if (n >= 0 && (n % R) == 0 && (n / R) < n_samp)
            acc += h[j] * samp[ch][n / R];
      end
      return acc[OUT_W-1:0];
   endfunction

   // Advance the model across one clock edge, then observe the DUT mid-cycle.
   task automatic step();
      if (reset) begin
         kcnt = 0; tick_m = 0; n_samp = 0;
         rate_act = rate_sel; next_tick = period(rate_sel) - 1;
         exp_valid = 1'b0;
         for (int c = 0; c < NCH; c++) exp_data[c] = '0;
      end else if (en) begin
         exp_valid = 1'b0;
         if (kcnt == next_tick) begin
            if ((tick_m % R) == 0) begin
               rate_act = rate_sel;
               if (n_samp < MAXS) begin
                  for (int c = 0; c < NCH; c++)
                     samp[c][n_samp] = longint'($signed(in_data[c*IN_W +: IN_W]));
                  n_samp++;
               end
            end
            for (int c = 0; c < NCH; c++) exp_data[c] = cic_out(c, tick_m);
            exp_valid = 1'b1;
            next_tick += period(rate_act);
            tick_m++;
         end
         kcnt++;
      end else begin
         exp_valid = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
      exp_req = en && (kcnt == next_tick) && ((tick_m % R) == 0);
      check("in_req", in_req, exp_req);
      check("out_valid", out_valid, exp_valid);
      if (exp_valid || out_valid || !en)
         for (int c = 0; c < NCH; c++)
            check($sformatf("out_data[%0d]", c), out_data[c*OUT_W +: OUT_W], exp_data[c]);
      if (out_valid) begin valid_gap = cyc - last_valid_cyc; last_valid_cyc = cyc; end
      if (in_req)    begin req_gap   = cyc - last_req_cyc;   last_req_cyc   = cyc; end
   endtask

   task automatic run_const(input int k, input logic [IN_W-1:0] c0, input logic [IN_W-1:0] c1);
      int target;
      target  = n_samp + k;
      in_data = {c1, c0};
      while (n_samp < target) step();
   endtask

   task automatic run_rand(input int k, input bit rand_en);
      int target;
      target = n_samp + k;
      while (n_samp < target) begin
         in_data = {$urandom, $urandom};
         if (rand_en) en = ($urandom_range(0, 7) != 0);
         step();
      end
      en = 1'b1;
   endtask

   task automatic check_settled(input string tag, input int ch, input longint fs);
      longint           e;
      logic [OUT_W-1:0] ev;
      e  = fs * gain;
      ev = e[OUT_W-1:0];
      check(tag, out_data[ch*OUT_W +: OUT_W], ev);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < HL; i++) h[i] = 0;
      h[0] = 1;
      for (int s = 0; s < N; s++) begin
         htmp = h;
         for (int i = 0; i < HL; i++) begin
            h[i] = 0;
            for (int k = 0; k < R; k++)
               if (i - k >= 0) h[i] += htmp[i-k];
         end
      end
      gain = 1;
      for (int s = 0; s < N - 1; s++) gain *= R;

      cyc = 0; last_valid_cyc = 0; last_req_cyc = 0; valid_gap = 0; req_gap = 0;
      reset = 1'b1; en = 1'b0; rate_sel = 2'd3; in_data = '0;
      repeat (3) step();
      reset = 1'b0; en = 1'b1;

      // Idle at fastest rate: zero outputs, 18-clk out_valid and 144-clk in_req spacing
      run_const(3, '0, '0);
      check("gap_valid_rate3", valid_gap, BASE_DIV);
      check("gap_req_rate3", req_gap, BASE_DIV * R);

      // Impulse on ch0, step of -1 on ch1, full-scale both polarities on ch0
      run_const(1, 32'd1, '0);
      run_const(4, '0, '0);
      run_const(5, '0, 32'hffff_ffff);
      check_settled("step_ch1_settle", 1, -1);
      run_const(5, 32'h7fff_ffff, '0);
      check_settled("fs_pos_settle", 0, 64'sd2147483647);
      run_const(5, 32'h8000_0000, '0);
      check_settled("fs_neg_settle", 0, -64'sd2147483648);

      // Rate change 3 -> 0 requested mid-phase; takes effect at the next input boundary
      run_rand(2, 1'b0);
      while ((tick_m % R) != 3) step();
      rate_sel = 2'd0;
      run_rand(3, 1'b0);
      check("gap_req_rate0", req_gap, BASE_DIV * 8 * R);
      check("gap_valid_rate0", valid_gap, BASE_DIV * 8);
      rate_sel = 2'd3;
      run_rand(2, 1'b0);

      // Random data with random enable gaps
      run_rand(6, 1'b1);

      // Reset with data in flight
      run_rand(2, 1'b0);
      while ((tick_m % R) != 4) step();
      reset = 1'b1;
      step();
      check("reset_clear_ch0", out_data[0 +: OUT_W], '0);
      check("reset_clear_valid", out_valid, 1'b0);
      reset = 1'b0;
      run_rand(3, 1'b0);

      // Enable held low for 50 clk mid-phase, then resume
      while ((tick_m % R) != 5) step();
      en = 1'b0;
      repeat (50) step();
      en = 1'b1;
      run_rand(3, 1'b0);
      run_const(4, '0, '0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/cic_interp_upsamp_ce.md
Name: cic_interp_upsamp_ce

Overview:
- Parametrised multi-channel CIC interpolator for the QAM transmit path, placed between the shaping-filter outputs and the modulator/DAC stage.
- Runs on one system clock, gated by internally generated clock enables; no derived or muxed clocks.
- Output rate is selected by `rate_sel` from a base divider, with a glitch-free rate change at sample boundaries.
- Generalises the channel count, stage count, interpolation ratio and widths, and adds a sample-request handshake.

Parameters:
- NCH, 2, number of channels (I/Q = 2).
- IN_W, 32, input sample width, two's complement.
- N, 2, CIC stage count (N combs + N integrators).
- LOG2R, 3, log2 of interpolation ratio R (R = 8).
- BASE_DIV, 18, clk cycles per output tick at fastest rate (rate_sel = 3).
- OUT_W, IN_W+(N-1)*LOG2R, output width (derived, full precision).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  global enable; low freezes all counters and state.
- rate_sel  in  2  0/1/2/3: output tick every BASE_DIV*8/4/2/1 clk.
- in_data  in  NCH*IN_W  packed channels, channel 0 in LSBs.
- in_req  out  1  one-clk pulse; in_data is sampled on this cycle.
- out_data  out  NCH*OUT_W  packed interpolated samples.
- out_valid  out  1  one-clk pulse when out_data updates.

Behaviour:
- Reset (synchronous, active-high):
  - All counters, comb delays, comb_reg, integrators and out_data are cleared to 0.
  - in_req = 0 and out_valid = 0.
  - rate_act is loaded from rate_sel.
  - Reset asserted mid-stream discards all state at the next edge; no partial output.
- Base divider:
  - bcnt runs 0..BASE_DIV-1 while en is high.
  - base_tick = (bcnt == BASE_DIV-1).
- Rate divider:
  - 3-bit dcnt increments on base_tick.
  - out_tick = base_tick AND (dcnt low (3-rate_act) bits all 1).
  - rate_act = 3 gives out_tick = base_tick.
- Phase counter:
  - ph counts 0..R-1 and advances on out_tick, wrapping R-1 -> 0.
  - in_tick = out_tick AND ph == 0.
- Rate change:
  - rate_act <= rate_sel only on in_tick cycles.
  - A change elsewhere takes effect at the next input boundary, so the first out_tick spacing after in_tick uses the new rate.
- en low: bcnt, dcnt, ph, comb, integrators and outputs hold; in_req = out_valid = 0.
- in_req = in_tick (combinational from registered counters); in_data is captured in the same cycle.
- Comb section, per channel, updated on in_tick only:
  - c0 = sign-extended input.
  - c_k = c_{k-1} - d_k, with d_k <= c_{k-1}.
  - comb_reg <= c_N.
- Integrator section, per channel, on every out_tick:
  - x = comb_reg if ph == 0, else 0. This is zero-stuffing, using the comb result of the previous input sample.
  - i_1 <= i_1 + x; i_k <= i_k + i_{k-1} (registered value).
- Arithmetic:
  - All comb and integrator registers are OUT_W bits, two's complement.
  - Add/sub wraps modulo 2^OUT_W; this is exact for CIC, so no saturation.
  - DC gain is R^(N-1).
- Output:
  - out_data <= i_N of each channel, and out_valid <= 1, on the clk after each out_tick.
  - Otherwise out_valid = 0 and out_data holds.
- Latency:
  - A sample captured at out_tick index 0 first affects out_data after out_tick R+N-1, visible one clk later.
  - Spacing between out_valid pulses = BASE_DIV*2^(3-rate_act) clk.
- Simultaneous events:
  - in_tick always coincides with an out_tick.
  - comb_reg update and its integrator use occur the same edge; the integrator uses the old comb_reg.

Test Plan:
- Reset then en=1, rate_sel=3, defaults:
  - out_valid every 18 clk and in_req every 144 clk, coincident with every 8th out_tick.
  - All outputs 0 while input is 0.
- Impulse, ch0 = 1 for one input sample, else 0 (N=2, R=8):
  - ch0 sequence starting at out_tick 9 is 1,2,3,4,5,6,7,8,7,6,5,4,3,2,1, then 0.
  - ch1 stays 0.
- Step, ch1 = -1 held:
  - Ramps -1..-8, then holds -8 (= -R^(N-1)).
  - Check 35-bit sign extension (default IN_W=32 gives OUT_W=35).
- Full-scale, ch0 = 2^31-1 held:
  - Settles at (2^31-1)*8 with no wrap error.
  - Same check with -2^31.
- Rate change 3 -> 0 mid-phase (ph=3):
  - Pulse spacing stays 18 until the next in_req, then becomes 144.
  - The in_req period becomes 1152.
  - Output values are identical to a constant-rate run.
- Reset asserted while nonzero data is in flight, and en held low for 50 clk:
  - Reset clears all outputs next edge.
  - en low holds out_data and suppresses out_valid/in_req; phase resumes unchanged when en returns high.
